// File: rtl/dm_arb.sv
// ---------------------------------------------------------------------------
// dm_arb -- two-port arbiter in front of a single-ported data memory.
//
// Each access walks IDLE -> ACCESS -> RESP, so one access is in flight at a
// time and the requester sees its ack two cycles after its request is taken.
// Ties between the ports are broken round-robin. Define DM_ARB_FIXED_PRI_EN
// for fixed priority instead: port 0 always wins and the pointer stays at 0.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   mX_req/we/addr/wdata       port X request (held until mX_ack)
//   mX_ack, mX_rdata           one-cycle completion pulse, read data (0 otherwise)
//   dm_addr, dm_din, dm_we     data memory address / write data / write strobe
//   dm_dout                    combinational read data from data memory
//   busy                       high whenever the FSM is not in IDLE
//   gnt_id                     port owning the current/last access
// ---------------------------------------------------------------------------
module dm_arb #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [31:0]       m0_wdata,
    output logic              m0_ack,
    output logic [31:0]       m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [31:0]       m1_wdata,
    output logic              m1_ack,
    output logic [31:0]       m1_rdata,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [31:0]       dm_din,
    output logic              dm_we,
    input  logic [31:0]       dm_dout,
    output logic              busy,
    output logic              gnt_id
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

    state_e              state_q, state_d;
    logic                ptr_q, ptr_d;
    logic                gnt_q, gnt_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [31:0]         rdata_q, rdata_d;

    logic any_req;
    logic win;

    assign any_req = m0_req | m1_req;

`ifdef DM_ARB_FIXED_PRI_EN
    // Port 1 only wins when port 0 is not asking.
    assign win = ~m0_req;
`else
    // On a tie the pointer names the winner; a lone requester always wins.
    assign win = (m0_req & m1_req) ? ptr_q : m1_req;
`endif

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (any_req) state_d = ACCESS;
            ACCESS:  state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ---------------- request / data registers ----------------
    always_comb begin
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        if (state_q == IDLE && any_req) begin
            gnt_d   = win;
            we_d    = win ? m1_we    : m0_we;
            addr_d  = win ? m1_addr  : m0_addr;
            wdata_d = win ? m1_wdata : m0_wdata;
`ifdef DM_ARB_FIXED_PRI_EN
            ptr_d   = 1'b0;
`else
            ptr_d   = ~win;
`endif
        end
        // Writes return zero so the requester never sees stale read data.
        if (state_q == ACCESS)
            rdata_d = we_q ? 32'h0 : dm_dout;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q   <= 1'b0;
            gnt_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // ---------------- outputs ----------------
    // Everything decodes from registered state, so reset clears the
    // outputs asynchronously along with the FSM.
    always_comb begin
        busy     = (state_q != IDLE);
        dm_we    = (state_q == ACCESS) && we_q;
        dm_addr  = addr_q;
        dm_din   = wdata_q;
        gnt_id   = gnt_q;
        m0_ack   = (state_q == RESP) && !gnt_q;
        m1_ack   = (state_q == RESP) &&  gnt_q;
        m0_rdata = m0_ack ? rdata_q : 32'h0;
        m1_rdata = m1_ack ? rdata_q : 32'h0;
    end

endmodule

// File: doc/dm_arb.md
DM_ARB -- requirements
Module: dm_arb

Interface
REQ-001 Parameter: ADDR_W, default 10, word-address width matching data-memory addr[11:2]; only value 10 supported.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 m0_req  input  1  port 0 access request; held high until m0_ack.
REQ-005 m0_we  input  1  port 0 write (1) / read (0).
REQ-006 m0_addr  input  ADDR_W  port 0 word address, bits [11:2].
REQ-007 m0_wdata  input  32  port 0 write data.
REQ-008 m0_ack  output  1  port 0 one-cycle completion pulse.
REQ-009 m0_rdata  output  32  port 0 read data, valid while m0_ack=1.
REQ-010 m1_req, m1_we, m1_addr, m1_wdata, m1_ack, m1_rdata: port 1, identical to port 0.
REQ-011 dm_addr  output  ADDR_W  address to data memory.
REQ-012 dm_din  output  32  write data to data memory.
REQ-013 dm_we  output  1  write strobe to data memory, sampled by memory on rising clk.
REQ-014 dm_dout  input  32  combinational read data from data memory.
REQ-015 busy  output  1  high in any state other than IDLE.
REQ-016 gnt_id  output  1  port owning the current/last access.

Function
REQ-017 FSM states: IDLE, ACCESS, RESP; exactly one access in flight.
REQ-018 IDLE: if any req high, select winner, register its we/addr/wdata, set gnt_id, go ACCESS; else stay IDLE.
REQ-019 Arbitration: round-robin; pointer names preferred port; both req high -> preferred port wins; pointer moves to the other port after every grant.
REQ-020 Single requester wins regardless of pointer; pointer still toggles away from the winner.
REQ-021 ACCESS: dm_addr/dm_din from registered request; dm_we=1 only if registered we=1; capture dm_dout into read-data register; go RESP.
REQ-022 RESP: assert winner's ack for exactly one cycle; rdata = captured value (reads), 0 for writes; go IDLE.
REQ-023 Latency: req sampled high in IDLE at edge N -> memory access cycle N+1 -> ack high in cycle N+2; back-to-back throughput one access per 3 cycles.
REQ-024 Outside ACCESS: dm_we=0; dm_addr/dm_din hold last registered values.
REQ-025 Non-granted port's ack stays 0; its rdata output is 0.
REQ-026 Requester dropping req before ack: in-flight access still completes and acks; no cancellation.
REQ-027 req held high in the cycle after ack is treated as a new request in IDLE.
REQ-028 Write-then-read same address, any port order: read returns newly written data.

Reset
REQ-029 rst_n low: immediately state=IDLE, pointer=port 0, gnt_id=0, m0_ack=m1_ack=0, dm_we=0, busy=0, dm_addr=0, dm_din=0, rdata registers=0.
REQ-030 Reset during ACCESS or RESP aborts the access; no ack issued; memory write occurs only if its edge preceded rst_n falling.
REQ-031 First grant after reset release no earlier than the first rising edge with rst_n high.

Configuration
REQ-032 Macro DM_ARB_FIXED_PRI_EN defined: port 0 always wins ties; pointer unused, held at 0.
REQ-033 Macro DM_ARB_FIXED_PRI_EN undefined: round-robin per REQ-019/020; all other behaviour identical.

Verification
REQ-034 Reset; m0 write addr 0x005 data 0xDEADBEEF -> dm_we=1 in one cycle with dm_addr=0x005, m0_ack in cycle N+2, mem[5]=0xDEADBEEF.
REQ-035 m1 read addr 0x005 after REQ-034 -> m1_ack at N+2 with m1_rdata=0xDEADBEEF, dm_we never high.
REQ-036 m0_req and m1_req held high together for 4 grants -> gnt_id order 0,1,0,1 (round-robin); with DM_ARB_FIXED_PRI_EN -> 0,0,0,0.
REQ-037 rst_n pulsed low during ACCESS of m1 write -> no m1_ack, busy=0 at once, state IDLE, next grant to port 0.
REQ-038 m0_req dropped in ACCESS cycle -> m0_ack still one-cycle pulse at N+2; m1 idle receives no ack.
